// File: rtl/donut_ray_sequencer_pkg.sv
// Shared types and constants for the donut ray sequencer slice.
package donut_ray_sequencer_pkg;

   localparam int Q8_FRAC = 8;
   localparam int VEC_W   = 16;

   typedef logic signed [VEC_W-1:0] vec_t;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      MARCH,
      CAPTURE,
      OUTPUT
   } state_t;

endpackage

// File: rtl/donut_ray_sequencer_if.sv
// Hit-tester launch bus plus the pixel valid/ready stream.
// master = sequencer side, slave = hit tester / pixel consumer side.
interface donut_ray_sequencer_if #(
   parameter int SHADE_BITS = 2
);
   import donut_ray_sequencer_pkg::*;

   logic                  start;
   vec_t                  px, py, pz;
   vec_t                  rx, ry, rz;
   vec_t                  lx, ly, lz;
   logic                  hit;
   vec_t                  light;
   logic                  pix_valid;
   logic                  pix_ready;
   logic                  pix_hit;
   logic [SHADE_BITS-1:0] pix_shade;

   modport master (
      output start, px, py, pz, rx, ry, rz, lx, ly, lz,
      input  hit, light,
      output pix_valid, pix_hit, pix_shade,
      input  pix_ready
   );

   modport slave (
      input  start, px, py, pz, rx, ry, rz, lx, ly, lz,
      output hit, light,
      input  pix_valid, pix_hit, pix_shade,
      output pix_ready
   );

endinterface

// File: rtl/donut_ray_sequencer_shade_quant.sv
// Combinational light-to-shade quantizer: clamp to [0,255], optional 2x2
// ordered dither (enabled by defining DONUT_DITHER_EN), then keep the top
// SHADE_BITS bits. A miss always yields shade 0.
module donut_shade_quant
   import donut_ray_sequencer_pkg::*;
#(
   parameter int SHADE_BITS = 2
) (
   input  vec_t                  light,
   input  logic                  hit,
   input  logic                  ix0,
   input  logic                  iy0,
   output logic [SHADE_BITS-1:0] shade
);

   localparam int CMAX = (1 << Q8_FRAC) - 1;

   logic [Q8_FRAC-1:0] c;
   logic [Q8_FRAC-1:0] cd;

   // Clamp the signed intensity into the unsigned 0..255 range.
   always_comb begin
      c = '0;
      if (light < 0)
         c = '0;
      else if (light > vec_t'(CMAX))
         c = Q8_FRAC'(CMAX);
      else
         c = light[Q8_FRAC-1:0];
   end

`ifdef DONUT_DITHER_EN
   logic [1:0]       d;
   logic [Q8_FRAC:0] sum;

   // Add the 2x2 ordered-dither offset for this pixel parity and re-clamp.
   always_comb begin
      d = 2'd0;
      case ({iy0, ix0})
         2'd0:    d = 2'd0;
         2'd1:    d = 2'd2;
         2'd2:    d = 2'd3;
         default: d = 2'd1;
      endcase
      sum = {1'b0, c} + ({{(Q8_FRAC-1){1'b0}}, d} << (6 - SHADE_BITS));
      cd  = sum[Q8_FRAC] ? Q8_FRAC'(CMAX) : sum[Q8_FRAC-1:0];
   end
`else
   wire dither_unused = ix0 ^ iy0;
   assign cd = c;
`endif

   assign shade = hit ? cd[Q8_FRAC-1 -: SHADE_BITS] : '0;

endmodule

// File: rtl/donut_ray_sequencer.sv
// Donut ray sequencer: walks an H_RAYS x V_RAYS ray grid per frame, launches
// the hit tester once per ray, samples after MARCH_STEPS cycles and streams
// one quantized pixel per ray. Optional dither: define DONUT_DITHER_EN.
module donut_ray_sequencer
   import donut_ray_sequencer_pkg::*;
#(
   parameter int H_RAYS      = 80,
   parameter int V_RAYS      = 60,
   parameter int MARCH_STEPS = 8,
   parameter int SHADE_BITS  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  vec_t                    p0x_in, p0y_in, p0z_in,
   input  vec_t                    r0x_in, r0y_in, rz_in,
   input  vec_t                    drx_in, dry_in,
   input  vec_t                    lx_in, ly_in, lz_in,
   donut_ray_sequencer_if.master   bus,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int CNT_W = (MARCH_STEPS > 1) ? $clog2(MARCH_STEPS) : 1;
   localparam int IX_W  = (H_RAYS > 1) ? $clog2(H_RAYS) : 1;
   localparam int IY_W  = (V_RAYS > 1) ? $clog2(V_RAYS) : 1;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IX_W-1:0]       ix_q, ix_d;
   logic [IY_W-1:0]       iy_q, iy_d;
   vec_t                  px_q, px_d, py_q, py_d, pz_q, pz_d;
   vec_t                  rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
   vec_t                  lx_q, lx_d, ly_q, ly_d, lz_q, lz_d;
   vec_t                  r0x_q, r0x_d, drx_q, drx_d, dry_q, dry_d;
   logic                  pix_hit_q, pix_hit_d;
   logic [SHADE_BITS-1:0] pix_shade_q, pix_shade_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;
   logic [SHADE_BITS-1:0] shade_w;
   logic                  last_col, last_row;

   donut_shade_quant #(.SHADE_BITS(SHADE_BITS)) u_quant (
      .light (bus.light),
      .hit   (bus.hit),
      .ix0   (ix_q[0]),
      .iy0   (iy_q[0]),
      .shade (shade_w)
   );

   assign last_col = (ix_q == IX_W'(H_RAYS - 1));
   assign last_row = (iy_q == IY_W'(V_RAYS - 1));

   // Next-state logic: frame latch, launch/march/capture timing, ray advance.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ix_d         = ix_q;
      iy_d         = iy_q;
      px_d         = px_q;
      py_d         = py_q;
      pz_d         = pz_q;
      rx_d         = rx_q;
      ry_d         = ry_q;
      rz_d         = rz_q;
      lx_d         = lx_q;
      ly_d         = ly_q;
      lz_d         = lz_q;
      r0x_d        = r0x_q;
      drx_d        = drx_q;
      dry_d        = dry_q;
      pix_hit_d    = pix_hit_q;
      pix_shade_d  = pix_shade_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               px_d    = p0x_in;
               py_d    = p0y_in;
               pz_d    = p0z_in;
               rx_d    = r0x_in;
               ry_d    = r0y_in;
               rz_d    = rz_in;
               lx_d    = lx_in;
               ly_d    = ly_in;
               lz_d    = lz_in;
               r0x_d   = r0x_in;
               drx_d   = drx_in;
               dry_d   = dry_in;
               ix_d    = '0;
               iy_d    = '0;
               busy_d  = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = MARCH;
         end
         MARCH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MARCH_STEPS - 1))
               state_d = CAPTURE;
         end
         CAPTURE: begin
            pix_hit_d   = bus.hit;
            pix_shade_d = shade_w;
            state_d     = OUTPUT;
         end
         OUTPUT: begin
            if (bus.pix_ready) begin
               if (!last_col) begin
                  ix_d = ix_q + 1'b1;
                  rx_d = rx_q + drx_q;
               end else begin
                  ix_d = '0;
                  rx_d = r0x_q;
                  ry_d = ry_q + dry_q;
                  iy_d = last_row ? '0 : iy_q + 1'b1;
               end
               if (last_col && last_row) begin
                  frame_done_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = IDLE;
               end else begin
                  state_d = LAUNCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ix_q         <= '0;
         iy_q         <= '0;
         px_q         <= '0;
         py_q         <= '0;
         pz_q         <= '0;
         rx_q         <= '0;
         ry_q         <= '0;
         rz_q         <= '0;
         lx_q         <= '0;
         ly_q         <= '0;
         lz_q         <= '0;
         r0x_q        <= '0;
         drx_q        <= '0;
         dry_q        <= '0;
         pix_hit_q    <= 1'b0;
         pix_shade_q  <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ix_q         <= ix_d;
         iy_q         <= iy_d;
         px_q         <= px_d;
         py_q         <= py_d;
         pz_q         <= pz_d;
         rx_q         <= rx_d;
         ry_q         <= ry_d;
         rz_q         <= rz_d;
         lx_q         <= lx_d;
         ly_q         <= ly_d;
         lz_q         <= lz_d;
         r0x_q        <= r0x_d;
         drx_q        <= drx_d;
         dry_q        <= dry_d;
         pix_hit_q    <= pix_hit_d;
         pix_shade_q  <= pix_shade_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.start     = (state_q == LAUNCH);
   assign bus.pix_valid = (state_q == OUTPUT);
   assign bus.pix_hit   = pix_hit_q;
   assign bus.pix_shade = pix_shade_q;
   assign bus.px        = px_q;
   assign bus.py        = py_q;
   assign bus.pz        = pz_q;
   assign bus.rx        = rx_q;
   assign bus.ry        = ry_q;
   assign bus.rz        = rz_q;
   assign bus.lx        = lx_q;
   assign bus.ly        = ly_q;
   assign bus.lz        = lz_q;
   assign busy          = busy_q;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_donut_ray_sequencer.sv
// Directed bench for donut_ray_sequencer on a 4x2 grid with a stubbed hit tester.
module tb_donut_ray_sequencer;
   import donut_ray_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   logic frame_start;
   vec_t p0x_in, p0y_in, p0z_in, r0x_in, r0y_in, rz_in;
   vec_t drx_in, dry_in, lx_in, ly_in, lz_in;
   logic busy, frame_done;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_start  = 0;
   int t_last   = 0;

   donut_ray_sequencer_if #(.SHADE_BITS(2)) bus ();

   donut_ray_sequencer #(
      .H_RAYS(4), .V_RAYS(2), .MARCH_STEPS(8), .SHADE_BITS(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .p0x_in(p0x_in), .p0y_in(p0y_in), .p0z_in(p0z_in),
      .r0x_in(r0x_in), .r0y_in(r0y_in), .rz_in(rz_in),
      .drx_in(drx_in), .dry_in(dry_in),
      .lx_in(lx_in), .ly_in(ly_in), .lz_in(lz_in),
      .bus(bus), .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_start();
      int n = 0;
      while (bus.start !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", {15'd0, bus.start}, 16'd1);
      t_last  = t_start;
      t_start = cyc;
   endtask

   int         lt[8] = '{200, -50, 100, 200, 255, 300, 64, 63};
   logic       ht[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [1:0] st[8] = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0};

   initial begin
      logic [15:0] erx, ery, egap;
      logic        saw;
      int          n;
      rst_n = 1'b0;
      frame_start = 1'b1;
      p0x_in = 16'h0100; p0y_in = 16'h0080; p0z_in = 16'hFC00;
      r0x_in = 16'hFF00; r0y_in = 16'hFFC0; rz_in  = 16'h0100;
      drx_in = 16'h0080; dry_in = 16'h0080;
      lx_in  = 16'h0040; ly_in  = 16'hFFC0; lz_in  = 16'h00B5;
      bus.hit = 1'b0; bus.light = '0; bus.pix_ready = 1'b1;

      // Reset with frame_start pulsed: nothing may move.
      repeat (3) @(negedge clk);
      check("rst_start", {15'd0, bus.start}, 16'd0);
      check("rst_valid", {15'd0, bus.pix_valid}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_done", {15'd0, frame_done}, 16'd0);
      check("rst_px", bus.px, 16'h0000);
      check("rst_shade", {14'd0, bus.pix_shade}, 16'd0);
      frame_start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_start", {15'd0, bus.start}, 16'd0);
      check("post_rst_busy", {15'd0, busy}, 16'd0);

      // Frame 1: 8 rays.
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_start();
         erx = 16'(-256 + 128 * (k % 4));
         ery = 16'(-64 + 128 * (k / 4));
         check("rx", bus.rx, erx);
         check("ry", bus.ry, ery);
         if (k > 0) begin
            egap = (k == 3) ? 16'd16 : 16'd11;
            check("start_gap", 16'(t_start - t_last), egap);
         end else begin
            check("busy_launch", {15'd0, busy}, 16'd1);
            check("px", bus.px, 16'h0100);
            check("pz", bus.pz, 16'hFC00);
            check("rz", bus.rz, 16'h0100);
            check("lz", bus.lz, 16'h00B5);
         end
         bus.hit = ht[k];
         bus.light = 16'(lt[k]);
         if (k == 2) bus.pix_ready = 1'b0;
         saw = 1'b0;
         if (k == 4) begin
            @(negedge clk);
            frame_start = 1'b1; r0x_in = 16'd1000; drx_in = 16'd7;
            @(negedge clk);
            frame_start = 1'b0;
            check("busy_mid", {15'd0, busy}, 16'd1);
         end
         n = 0;
         while (bus.pix_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.start === 1'b1) saw = 1'b1;
         end
         check("valid_lat", 16'(cyc - t_start), 16'd10);
         check("no_extra_start", {15'd0, saw}, 16'd0);
         check("pix_hit", {15'd0, bus.pix_hit}, {15'd0, ht[k]});
         check("pix_shade", {14'd0, bus.pix_shade}, {14'd0, st[k]});
         if (k == 2) begin
            for (int i = 0; i < 5; i++) begin
               check("bp_valid", {15'd0, bus.pix_valid}, 16'd1);
               check("bp_nostart", {15'd0, bus.start}, 16'd0);
               check("bp_shade", {14'd0, bus.pix_shade}, 16'd1);
               @(negedge clk);
            end
            check("bp_valid_end", {15'd0, bus.pix_valid}, 16'd1);
            bus.pix_ready = 1'b1;
         end
         @(negedge clk);
         if (k == 7) begin
            check("frame_done", {15'd0, frame_done}, 16'd1);
            check("busy_end", {15'd0, busy}, 16'd0);
            check("end_nostart", {15'd0, bus.start}, 16'd0);
            @(negedge clk);
            check("frame_done_once", {15'd0, frame_done}, 16'd0);
         end
      end

      // Frame 2 restarts from the newly latched origin column.
      r0x_in = 16'h0200;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      wait_start();
      check("restart_rx", bus.rx, 16'h0200);
      check("restart_ry", bus.ry, 16'hFFC0);

      // Asynchronous reset in MARCH.
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_start", {15'd0, bus.start}, 16'd0);
      check("arst_busy", {15'd0, busy}, 16'd0);
      check("arst_rx", bus.rx, 16'h0000);
      check("arst_px", bus.px, 16'h0000);
      check("arst_hit", {15'd0, bus.pix_hit}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.start === 1'b1 || bus.pix_valid === 1'b1) saw = 1'b1;
      end
      check("idle_after_arst", {15'd0, saw}, 16'd0);
      check("idle_busy", {15'd0, busy}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/donut_ray_sequencer.md
Name: donut_ray_sequencer

Overview:
Initiator for the donut ray-march hit tester. Walks a per-frame grid of rays and, for each ray, drives the origin, ray direction and light vectors with a one-cycle start pulse. Waits the fixed march latency, samples hit and light, quantizes them to a shade, and emits one pixel per ray on a valid/ready stream toward the frame/line buffer.

Parameters:
H_RAYS, 80, rays per row (ix = 0..H_RAYS-1)
V_RAYS, 60, rows per frame (iy = 0..V_RAYS-1)
MARCH_STEPS, 8, non-start cycles the hit tester iterates before its outputs are sampled
SHADE_BITS, 2, width of the quantized shade output

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  pulse; latches the camera/light inputs and starts a frame when idle
p0x_in, p0y_in, p0z_in  in  16 each  signed Q8 ray origin, constant for the frame
r0x_in, r0y_in, rz_in  in  16 each  signed Q8 direction of ray (0,0)
drx_in, dry_in  in  16 each  signed Q8 per-column x step and per-row y step
lx_in, ly_in, lz_in  in  16 each  signed Q8 light direction
start  out  1  one-cycle launch pulse to the hit tester
px, py, pz, rx, ry, rz, lx, ly, lz  out  16 each  vectors presented to the hit tester
hit  in  1  hit flag from the hit tester
light  in  16  signed Q8 light intensity from the hit tester
pix_valid  out  1  pixel result available
pix_ready  in  1  consumer accepts the pixel
pix_hit  out  1  ray hit the torus
pix_shade  out  SHADE_BITS  quantized intensity
busy  out  1  high from frame launch until the last pixel is accepted
frame_done  out  1  one-cycle pulse when the last pixel of the frame is accepted

Behaviour:
- Reset: all outputs 0 (start, pix_valid, pix_hit, pix_shade, busy, frame_done, all vectors), FSM in IDLE, ix = iy = 0. The asynchronous reset aborts any frame immediately.
- IDLE: on frame_start, latch all *_in vectors; set rx = r0x, ry = r0y, ix = iy = 0; busy = 1; go to LAUNCH. frame_start in any state other than IDLE is ignored.
- LAUNCH (1 cycle): start = 1 while px..lz hold the current ray. Next state is MARCH with cnt = 0.
- MARCH: start = 0 and all vectors held stable. cnt increments each cycle. After MARCH_STEPS cycles, go to CAPTURE.
- CAPTURE (1 cycle): register pix_hit = hit and pix_shade = q(light) from the value at the clock edge. Go to OUTPUT.
- q(light): c = clamp(light, 0, 255); shade = c >> (8 - SHADE_BITS). The shade is forced to 0 when hit = 0.
- OUTPUT: pix_valid = 1, with pix_hit and pix_shade held stable until pix_valid && pix_ready. On acceptance, advance the ray:
  - if ix < H_RAYS-1: ix++, rx += drx.
  - otherwise: ix = 0, rx = r0x, iy++, ry += dry.
  - If the accepted pixel is (H_RAYS-1, V_RAYS-1): frame_done = 1 for one cycle, busy = 0, go to IDLE. Otherwise go to LAUNCH.
- Ray vectors are never recomputed by multiplication. They use incremental 16-bit two's-complement adds, wrap on overflow, no saturation.
- Minimum per-ray period is MARCH_STEPS + 3 cycles (11 at defaults) with pix_ready held high. Back-pressure only stretches OUTPUT.
- pix_valid never drops without acceptance, and no start is issued while pix_valid is pending.

Optional Feature:
DONUT_DITHER_EN: when defined, a 2x2 ordered dither offset {0,2,3,1}[{iy[0],ix[0]}] << (6 - SHADE_BITS) is added to c before the shift, re-clamped to 255. When undefined, plain truncation as above.

Decomposition:
- Shared package: the FSM state enum (IDLE, LAUNCH, MARCH, CAPTURE, OUTPUT), the Q8 fraction-width constant (8), and the vector width constant (16).
- One natural sub-module, donut_shade_quant: combinational clamp, dither, and shift from light, hit, ix[0], iy[0] to shade.

Test Plan:
- Reset with rst_n = 0 -> start = pix_valid = busy = frame_done = 0; frame_start pulsed during reset has no effect.
- H_RAYS=4, V_RAYS=2, r0x=-256, drx=128, r0y=-64, dry=128, frame_start -> rx at successive starts is -256, -128, 0, 128, -256, ...; ry is -64 for 4 starts, then 64; start pulses are 11 cycles apart with pix_ready = 1.
- Stub the hit tester to return hit=1, light=200 -> pix_shade = 3. hit=1, light=-50 -> 0. hit=1, light=100 -> 1. hit=0, light=200 -> pix_hit = 0, shade 0.
- Hold pix_ready = 0 for 5 cycles in OUTPUT -> pix_valid and data stable, no start issued. Release -> next start 1 cycle after acceptance.
- frame_start asserted mid-frame -> ignored. After the 8th pixel is accepted -> frame_done pulses once, busy falls, a new frame_start restarts at rx = r0x.
- rst_n dropped during MARCH -> outputs immediately 0 and FSM in IDLE. After release, no start until frame_start.
